// File: rtl/cpu_dma_bus_scheduler.sv
// Time-slot scheduler sharing one synchronous RAM between the 8080 CPU core and a DMA read port.
// The CPU gets one access per CPU_DIV-clock slot; spare phases and whole HOLD slots serve DMA reads.
module cpu_dma_bus_scheduler #(
    parameter int CPU_DIV = 8,   // clocks per slot, 3..32
    parameter int AW      = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_address,
    input  logic [7:0]    cpu_out,
    input  logic          cpu_we,
    output logic          cpu_ce,
    output logic [7:0]    cpu_in,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    output logic          dma_ack,
    output logic          dma_valid,
    output logic [7:0]    dma_data,
    input  logic          dma_hold,
    output logic          dma_hlda,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_q
);
    localparam int            PW          = $clog2(CPU_DIV);
    localparam logic [PW-1:0] PH_CPU_ADDR = PW'(0);
    localparam logic [PW-1:0] PH_CPU_DATA = PW'(1);
    localparam logic [PW-1:0] PH_LAST     = PW'(CPU_DIV - 1);

    logic [PW-1:0] ph_q;
    logic [PW-1:0] ph_d;
    logic          hold_slot_q;
    logic          hold_slot_d;
    logic          dma_valid_q;
    logic          dma_valid_d;
    logic          ph_last;
    logic          issue_phase;

    always_comb begin
        ph_last     = (ph_q == PH_LAST);
        ph_d        = ph_last ? '0 : ph_q + 1'b1;
        // Hold is only ever decided at a slot boundary, so a CPU slot is never cut short.
        hold_slot_d = ph_last ? dma_hold : hold_slot_q;
        issue_phase = hold_slot_q || (ph_q > PH_CPU_DATA);

        dma_ack     = reset_n && issue_phase && dma_req;
        dma_valid_d = dma_ack;
        cpu_ce      = reset_n && !hold_slot_q && (ph_q == PH_CPU_DATA);
        mem_we      = reset_n && !hold_slot_q && (ph_q == PH_CPU_ADDR) && cpu_we;
        mem_addr    = dma_ack ? dma_addr : cpu_address;
    end

    assign mem_wdata = cpu_out;
    assign cpu_in    = mem_q;
    assign dma_data  = mem_q;
    assign dma_hlda  = hold_slot_q;
    // A read in flight when reset arrives is dropped rather than reported.
    assign dma_valid = dma_valid_q && reset_n;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ph_q        <= '0;
            hold_slot_q <= 1'b0;
            dma_valid_q <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            hold_slot_q <= hold_slot_d;
            dma_valid_q <= dma_valid_d;
        end
    end
endmodule

// File: tb/tb_cpu_dma_bus_scheduler.sv
// Bench for cpu_dma_bus_scheduler: directed slot scenarios plus randomized traffic
// checked against a cycle-count based model of the slot rules and a model RAM.
module tb_cpu_dma_bus_scheduler;
    localparam int DIV  = 8;
    localparam int DIVB = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A (CPU_DIV=8)
    logic        reset_n;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_we;
    logic        cpu_ce;
    logic [7:0]  cpu_in;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_ack;
    logic        dma_valid;
    logic [7:0]  dma_data;
    logic        dma_hold;
    logic        dma_hlda;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_q;

    // Instance B (CPU_DIV=3)
    logic        reset_n_b;
    logic [15:0] cpu_address_b;
    logic [7:0]  cpu_out_b;
    logic        cpu_we_b;
    logic        cpu_ce_b;
    logic [7:0]  cpu_in_b;
    logic        dma_req_b;
    logic [15:0] dma_addr_b;
    logic        dma_ack_b;
    logic        dma_valid_b;
    logic [7:0]  dma_data_b;
    logic        dma_hold_b;
    logic        dma_hlda_b;
    logic [15:0] mem_addr_b;
    logic [7:0]  mem_wdata_b;
    logic        mem_we_b;
    logic [7:0]  mem_q_b;

    cpu_dma_bus_scheduler #(.CPU_DIV(DIV), .AW(16)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
        .cpu_ce(cpu_ce), .cpu_in(cpu_in),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack),
        .dma_valid(dma_valid), .dma_data(dma_data),
        .dma_hold(dma_hold), .dma_hlda(dma_hlda),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q)
    );

    cpu_dma_bus_scheduler #(.CPU_DIV(DIVB), .AW(16)) dut_b (
        .clock(clock), .reset_n(reset_n_b),
        .cpu_address(cpu_address_b), .cpu_out(cpu_out_b), .cpu_we(cpu_we_b),
        .cpu_ce(cpu_ce_b), .cpu_in(cpu_in_b),
        .dma_req(dma_req_b), .dma_addr(dma_addr_b), .dma_ack(dma_ack_b),
        .dma_valid(dma_valid_b), .dma_data(dma_data_b),
        .dma_hold(dma_hold_b), .dma_hlda(dma_hlda_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_q(mem_q_b)
    );

    // Board RAM for A: read-first synchronous RAM preloaded with addr[7:0].
    logic [7:0] ram [0:65535];
    logic       ram_ready = 1'b0;
    always @(posedge clock) begin
        if (!ram_ready) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'(i);
            ram_ready <= 1'b1;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_q <= ram[mem_addr];
    end

    // B sees an address-derived read-only memory.
    always @(posedge clock) mem_q_b <= mem_addr_b[7:0] ^ 8'hA5;

    int checks = 0;
    int errors = 0;

    // Reference model for A: slot position from the cycle count since reset release.
    logic [7:0]  ref_mem [0:65535];
    int          m_cyc;
    int          m_ph;
    bit          m_hold;
    bit          m_prev_ack;
    logic [15:0] m_prev_addr;
    logic [7:0]  m_rd_data;
    bit          e_ce, e_ack, e_we, e_valid;
    logic [15:0] e_addr;
    logic [7:0]  e_data;

    task automatic expect_now();
        m_ph    = m_cyc % DIV;
        e_ce    = reset_n && !m_hold && m_ph == 1;
        e_ack   = reset_n && dma_req && (m_hold || m_ph >= 2);
        e_we    = reset_n && !m_hold && m_ph == 0 && cpu_we;
        e_addr  = e_ack ? dma_addr : cpu_address;
        e_valid = m_prev_ack;
        e_data  = ref_mem[m_prev_addr];
    endtask

    task automatic advance();
        expect_now();
        if (!reset_n) begin
            m_cyc      = 0;
            m_hold     = 0;
            m_prev_ack = 0;
        end else begin
            if (m_ph == 0 && !m_hold) m_rd_data = ref_mem[cpu_address];
            if (e_we) ref_mem[cpu_address] = cpu_out;
            if (m_ph == DIV - 1) m_hold = dma_hold;
            m_prev_ack  = e_ack;
            m_prev_addr = dma_addr;
            m_cyc++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic align_slot();
        while (m_cyc % DIV != 0) advance();
    endtask

    task automatic test_reset();
        bit prev_ce = 0;
        reset_n = 0; cpu_address = 16'h0100; cpu_out = 8'h00; cpu_we = 1'b1;
        dma_req = 1'b1; dma_addr = 16'h7600; dma_hold = 1'b0;
        repeat (3) advance();
        #1;
        checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL rst_ce got %b want 0", cpu_ce); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", mem_we); end
        checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", dma_ack); end
        checks++; if (dma_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", dma_valid); end
        checks++; if (dma_hlda !== 1'b0) begin errors++; $display("FAIL rst_hlda got %b want 0", dma_hlda); end
        advance();
        reset_n = 1; cpu_we = 0; dma_req = 0;
        for (int k = 0; k < 24; k++) begin
            #1;
            checks++;
            if (cpu_ce !== (k == 1 || k == 9 || k == 17)) begin
                errors++; $display("FAIL rel_ce cyc=%0d got %b want %b", k, cpu_ce, (k == 1 || k == 9 || k == 17));
            end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rel_we cyc=%0d got %b want 0", k, mem_we); end
            if (prev_ce && cpu_ce === 1'b1) begin errors++; $display("FAIL rel_ce_twice cyc=%0d got 1 want 0", k); end
            prev_ce = (cpu_ce === 1'b1);
            advance();
        end
        $display("test_reset done cycles=24");
    endtask

    task automatic test_dma_stream();
        int  seq = 0;
        int  acks = 0;
        bit  step;
        align_slot();
        cpu_we = 0; cpu_address = 16'h1234; dma_req = 1; dma_addr = 16'h7600;
        for (int k = 0; k < 16; k++) begin
            int p = k % DIV;
            #1;
            expect_now();
            checks++; if (dma_ack !== (p >= 2)) begin errors++; $display("FAIL str_ack k=%0d got %b want %b", k, dma_ack, (p >= 2)); end
            checks++; if (mem_addr !== (p >= 2 ? dma_addr : cpu_address)) begin
                errors++; $display("FAIL str_addr k=%0d got %h want %h", k, mem_addr, (p >= 2 ? dma_addr : cpu_address));
            end
            checks++; if (dma_valid !== (p >= 3 || (p == 0 && k > 0))) begin
                errors++; $display("FAIL str_valid k=%0d got %b want %b", k, dma_valid, (p >= 3 || (p == 0 && k > 0)));
            end
            if (dma_valid === 1'b1) begin
                checks++; if (dma_data !== 8'(seq)) begin errors++; $display("FAIL str_data k=%0d got %h want %h", k, dma_data, 8'(seq)); end
                seq++;
            end
            if (p == 1) begin
                checks++; if (cpu_ce !== 1'b1) begin errors++; $display("FAIL str_ce k=%0d got %b want 1", k, cpu_ce); end
                checks++; if (cpu_in !== 8'h34) begin errors++; $display("FAIL str_cpu_in k=%0d got %h want 34", k, cpu_in); end
            end
            if (dma_ack === 1'b1) acks++;
            step = e_ack;
            advance();
            if (step) dma_addr++;
        end
        checks++; if (acks != 12) begin errors++; $display("FAIL str_ack_count got %0d want 12", acks); end
        dma_req = 0;
        $display("test_dma_stream done acks=%0d data_seen=%0d", acks, seq);
    endtask

    task automatic test_cpu_write();
        align_slot();
        cpu_we = 1; cpu_address = 16'h7600; cpu_out = 8'h55; dma_req = 0;
        for (int k = 0; k < 10; k++) begin
            int p = k % DIV;
            if (k == 8) cpu_we = 0;
            #1;
            checks++; if (mem_we !== (k == 0)) begin errors++; $display("FAIL wr_we k=%0d got %b want %b", k, mem_we, (k == 0)); end
            checks++; if (mem_addr !== 16'h7600) begin errors++; $display("FAIL wr_addr k=%0d got %h want 7600", k, mem_addr); end
            if (p == 0 && k == 0) begin
                checks++; if (mem_wdata !== 8'h55) begin errors++; $display("FAIL wr_wdata got %h want 55", mem_wdata); end
            end
            if (k == 9) begin
                checks++; if (cpu_in !== 8'h55) begin errors++; $display("FAIL wr_readback got %h want 55", cpu_in); end
            end
            advance();
        end
        $display("test_cpu_write done addr=7600 data=55");
    endtask

    task automatic test_hold();
        int  acks1 = 0;
        bit  step;
        align_slot();
        cpu_we = 0; dma_req = 1; dma_hold = 0;
        for (int k = 0; k < 24; k++) begin
            int slot = k / DIV;
            int p = k % DIV;
            if (slot == 0 && p == 4) dma_hold = 1;
            if (slot == 1 && p == 3) dma_hold = 0;
            #1;
            expect_now();
            checks++; if (dma_hlda !== (slot == 1)) begin errors++; $display("FAIL hold_hlda k=%0d got %b want %b", k, dma_hlda, (slot == 1)); end
            checks++; if (cpu_ce !== (slot != 1 && p == 1)) begin errors++; $display("FAIL hold_ce k=%0d got %b want %b", k, cpu_ce, (slot != 1 && p == 1)); end
            checks++; if (dma_ack !== (slot == 1 || p >= 2)) begin errors++; $display("FAIL hold_ack k=%0d got %b want %b", k, dma_ack, (slot == 1 || p >= 2)); end
            if (slot == 1 && dma_ack === 1'b1) acks1++;
            step = e_ack;
            advance();
            if (step) dma_addr++;
        end
        checks++; if (acks1 != DIV) begin errors++; $display("FAIL hold_ack_count got %0d want %0d", acks1, DIV); end
        dma_req = 0;
        $display("test_hold done hold_slot_acks=%0d", acks1);
    endtask

    task automatic test_reset_mid();
        align_slot();
        cpu_we = 0; dma_req = 1; dma_hold = 0;
        repeat (5) begin
            advance();
            dma_addr++;
        end
        reset_n = 0;
        #1;
        checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL rm_ack got %b want 0", dma_ack); end
        checks++; if (cpu_ce !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rm_strobes got %b%b want 00", cpu_ce, mem_we); end
        advance();
        #1;
        checks++; if (dma_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b want 0", dma_valid); end
        checks++; if (dma_ack !== 1'b0 || cpu_ce !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rm_strobes2 got %b%b%b want 000", dma_ack, cpu_ce, mem_we);
        end
        advance();
        reset_n = 1; dma_req = 0;
        for (int k = 0; k < 18; k++) begin
            #1;
            checks++;
            if (cpu_ce !== (k == 1 || k == 9 || k == 17)) begin
                errors++; $display("FAIL rm_ce cyc=%0d got %b want %b", k, cpu_ce, (k == 1 || k == 9 || k == 17));
            end
            if (k == 0) begin
                checks++; if (dma_valid !== 1'b0) begin errors++; $display("FAIL rm_valid_rel got %b want 0", dma_valid); end
            end
            advance();
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        bit last_ack, last_ce;
        for (int k = 0; k < 400; k++) begin
            #1;
            expect_now();
            checks++; if (cpu_ce !== e_ce) begin errors++; $display("FAIL rnd_ce k=%0d got %b want %b", k, cpu_ce, e_ce); end
            checks++; if (dma_ack !== e_ack) begin errors++; $display("FAIL rnd_ack k=%0d got %b want %b", k, dma_ack, e_ack); end
            checks++; if (mem_we !== e_we) begin errors++; $display("FAIL rnd_we k=%0d got %b want %b", k, mem_we, e_we); end
            checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr k=%0d got %h want %h", k, mem_addr, e_addr); end
            checks++; if (dma_hlda !== m_hold) begin errors++; $display("FAIL rnd_hlda k=%0d got %b want %b", k, dma_hlda, m_hold); end
            checks++; if (dma_valid !== e_valid) begin errors++; $display("FAIL rnd_valid k=%0d got %b want %b", k, dma_valid, e_valid); end
            if (e_valid) begin
                checks++; if (dma_data !== e_data) begin errors++; $display("FAIL rnd_data k=%0d got %h want %h", k, dma_data, e_data); end
            end
            if (e_we) begin
                checks++; if (mem_wdata !== cpu_out) begin errors++; $display("FAIL rnd_wdata k=%0d got %h want %h", k, mem_wdata, cpu_out); end
            end
            if (e_ce) begin
                checks++; if (cpu_in !== m_rd_data) begin errors++; $display("FAIL rnd_cpu_in k=%0d got %h want %h", k, cpu_in, m_rd_data); end
            end
            last_ack = e_ack;
            last_ce  = e_ce;
            advance();
            dma_req = ($urandom_range(0, 3) != 0);
            if (last_ack) dma_addr++;
            else if ($urandom_range(0, 7) == 0) dma_addr = 16'($urandom);
            if (last_ce) begin
                cpu_address = 16'h7000 | 16'($urandom_range(0, 255));
                cpu_out     = 8'($urandom);
                cpu_we      = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 11) == 0) dma_hold = ~dma_hold;
        end
        dma_hold = 0; dma_req = 0; cpu_we = 0;
        $display("test_random done cycles=400");
    endtask

    task automatic test_div3();
        bit          prev_ack = 0;
        logic [15:0] prev_addr = 16'h0;
        int          acks2 = 0;
        reset_n_b = 1; cpu_we_b = 1; cpu_address_b = 16'h0042; cpu_out_b = 8'h99;
        dma_req_b = 1; dma_addr_b = 16'h0300; dma_hold_b = 0;
        for (int k = 0; k < 15; k++) begin
            int slot = k / DIVB;
            int p = k % DIVB;
            if (k == 4) dma_hold_b = 1;
            if (k == 6) dma_hold_b = 0;
            #1;
            checks++; if (cpu_ce_b !== (slot != 2 && p == 1)) begin errors++; $display("FAIL d3_ce k=%0d got %b want %b", k, cpu_ce_b, (slot != 2 && p == 1)); end
            checks++; if (dma_ack_b !== (slot == 2 || p == 2)) begin errors++; $display("FAIL d3_ack k=%0d got %b want %b", k, dma_ack_b, (slot == 2 || p == 2)); end
            checks++; if (dma_hlda_b !== (slot == 2)) begin errors++; $display("FAIL d3_hlda k=%0d got %b want %b", k, dma_hlda_b, (slot == 2)); end
            checks++; if (mem_we_b !== (slot != 2 && p == 0)) begin errors++; $display("FAIL d3_we k=%0d got %b want %b", k, mem_we_b, (slot != 2 && p == 0)); end
            checks++; if (dma_valid_b !== prev_ack) begin errors++; $display("FAIL d3_valid k=%0d got %b want %b", k, dma_valid_b, prev_ack); end
            if (prev_ack) begin
                checks++; if (dma_data_b !== (prev_addr[7:0] ^ 8'hA5)) begin
                    errors++; $display("FAIL d3_data k=%0d got %h want %h", k, dma_data_b, prev_addr[7:0] ^ 8'hA5);
                end
            end
            if (mem_we_b === 1'b1) begin
                checks++; if (mem_wdata_b !== 8'h99) begin errors++; $display("FAIL d3_wdata k=%0d got %h want 99", k, mem_wdata_b); end
            end
            if (slot != 2 && p == 1) begin
                checks++; if (cpu_in_b !== (8'h42 ^ 8'hA5)) begin errors++; $display("FAIL d3_cpu_in k=%0d got %h want %h", k, cpu_in_b, 8'h42 ^ 8'hA5); end
            end
            if (slot == 2 && dma_ack_b === 1'b1) acks2++;
            prev_ack  = (slot == 2 || p == 2);
            prev_addr = dma_addr_b;
            @(posedge clock);
            #1;
            if (prev_ack) dma_addr_b++;
        end
        checks++; if (acks2 != DIVB) begin errors++; $display("FAIL d3_hold_acks got %0d want %0d", acks2, DIVB); end
        $display("test_div3 done hold_slot_acks=%0d", acks2);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i);
        m_cyc = 0; m_hold = 0; m_prev_ack = 0; m_prev_addr = 16'h0; m_rd_data = 8'h00;
        reset_n_b = 0; cpu_address_b = 16'h0; cpu_out_b = 8'h0; cpu_we_b = 0;
        dma_req_b = 0; dma_addr_b = 16'h0; dma_hold_b = 0;
        test_reset();
        test_dma_stream();
        test_cpu_write();
        test_hold();
        test_reset_mid();
        test_random();
        test_div3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_dma_bus_scheduler.md
Name: cpu_dma_bus_scheduler

Overview:
- Time-slot scheduler that shares the single synchronous board RAM between the KR580VM80A CPU core and a video/DMA read requester.
- Generates the CPU clock-enable, so the CPU gets exactly one memory access per slot.
- Spare cycles in each slot go to pipelined DMA reads.
- Also implements an 8080-style HOLD/HLDA bus grant: the requester can take whole slots for bursts while the CPU is frozen.

Parameters:
- CPU_DIV, 8, system clocks per slot (CPU runs at clock/CPU_DIV); legal range 3..32.
- AW, 16, memory address width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- cpu_address  in  AW  CPU bus address
- cpu_out  in  8  CPU write data
- cpu_we  in  1  CPU write request; held by the CPU until its next ce
- cpu_ce  out  1  CPU clock enable
- cpu_in  out  8  read data to CPU
- dma_req  in  1  DMA read request (level)
- dma_addr  in  AW  DMA read address
- dma_ack  out  1  dma_addr consumed this cycle
- dma_valid  out  1  dma_data valid
- dma_data  out  8  DMA read data
- dma_hold  in  1  request whole slots (CPU frozen)
- dma_hlda  out  1  hold acknowledged
- mem_addr  out  AW  RAM address
- mem_wdata  out  8  RAM write data
- mem_we  out  1  RAM write strobe
- mem_q  in  8  RAM read data, 1-cycle synchronous latency

Behaviour:
Registered state and reset:
- Registered: phase counter ph (0..CPU_DIV-1, wraps), hold_slot flag, dma_valid.
- Reset values: ph=0, hold_slot=0, dma_valid=0, dma_hlda=0.
- All strobes (cpu_ce, mem_we, dma_ack) are forced 0 while reset_n=0.
- Reset mid-slot or mid-burst abandons any in-flight DMA read: no dma_valid is issued for it.

Slot types:
- CPU slot (hold_slot=0):
  - ph=0: mem_addr=cpu_address; mem_we=cpu_we; mem_wdata=cpu_out. This is the only cycle mem_we can be 1, so there is exactly one write per CPU access.
  - ph=1: cpu_ce=1, cpu_in=mem_q (data addressed at ph=0). mem_addr=cpu_address, no write.
  - ph=2..CPU_DIV-1: DMA issue phases.
- Hold slot (hold_slot=1):
  - cpu_ce=0 and mem_we=0 for the whole slot.
  - Every phase 0..CPU_DIV-1 is a DMA issue phase.

DMA issue phase:
- If dma_req=1: mem_addr=dma_addr and dma_ack=1 (combinational). The requester advances dma_addr on the next edge.
- If dma_req=0: mem_addr=cpu_address, dma_ack=0.
- dma_valid is registered dma_ack, i.e. valid exactly one cycle after the ack. dma_data=mem_q.
- A read issued at ph=CPU_DIV-1 completes at the next slot's ph=0. This does not conflict, because the CPU read data is consumed at ph=1.

Hold arbitration:
- dma_hold is sampled only at ph=CPU_DIV-1; hold_slot takes the sampled value for the next slot.
- dma_hlda = hold_slot, so it changes only at slot boundaries.
- Asserting dma_hold mid-slot never truncates the current CPU slot.
- Releasing dma_hold mid-hold-slot completes that slot; the CPU resumes at the next slot.

Other rules:
- cpu_ce period is exactly CPU_DIV clocks when no hold is active. First cpu_ce is at the 2nd clock after reset release.
- cpu_in follows mem_q at all times; the CPU only samples it under cpu_ce.
- CPU I/O port cycles do not pass through this block.

Test Plan:
- Reset release, CPU_DIV=8, dma_req=0 → cpu_ce high on cycles 1, 9, 17 after release. Never two consecutive cycles. mem_we=0 throughout.
- CPU write: cpu_we=1, cpu_address=16'h7600, cpu_out=8'h55 held for the slot → mem_we=1 only at ph=0 with mem_addr=16'h7600, mem_wdata=8'h55. No write at ph=1..7.
- Continuous dma_req with incrementing dma_addr from 16'h7600 (RAM preloaded addr[7:0]) → 6 acks per slot at ph=2..7. dma_valid at ph=3..7 and the next ph=0, with data 00,01,02,…. No ack at ph=0/1. CPU read at ph=1 returns the RAM byte at cpu_address.
- dma_hold asserted at ph=4 → current slot still gives cpu_ce at ph=1. dma_hlda rises at the next ph=0. That slot gives 8 acks and no cpu_ce. Drop hold at ph=3 of that slot → hlda falls at the next ph=0, with cpu_ce at ph=1.
- reset_n low at ph=5 during a burst → the next cycle has no dma_valid and no strobes. After release, ph restarts at 0 and timing matches the first scenario.
- CPU_DIV=3 → 1 DMA issue phase per CPU slot (ph=2). cpu_ce period is 3. Hold slots give 3 acks.
